mac_job_sequencer: RTL and testbench
====================================

// Module: mac_job_sequencer
// PURPOSE
//  Sequences one mac_cluster through a complete MAC job: accepts a job command (cfg word + beat count),
//  preloads the accumulators via cset, streams operand beats into the cluster, flushes the output
//  pipeline, then returns the four accumulator lanes through a result handshake. Sits directly
//  in front of mac_cluster; the parent splits the packed operand buses onto A0..A3/B0..B3.
// PARAMETERS
//  MAC_CONF_WIDTH  4                 cfg control field: [1:0] mode (`MAC_SINGLE/`MAC_DUAL/`MAC_QUAD), [2] accumulate, [3] signed
//  MAC_MIN_WIDTH   8                 width of one operand lane
//  MAC_ACC_WIDTH   4*MAC_MIN_WIDTH   width of one accumulator lane
//  MAC_LAT         2                 cycles from an en=1 beat at the cluster inputs to its effect on out0..out3
//  LEN_WIDTH       16                width of the beat count
// PORTS
//  clk        in   1                       clock
//  rst        in   1                       synchronous active-high reset
//  cmd_valid  in   1                       job command valid
//  cmd_ready  out  1                       job command ready
//  cmd_cfg    in   4*MAC_ACC_WIDTH+MAC_CONF_WIDTH  {init3,init2,init1,init0,ctrl}, same layout as cluster cfg
//  cmd_len    in   LEN_WIDTH               operand beats in the job (0 is legal)
//  op_valid   in   1                       operand beat valid
//  op_ready   out  1                       operand beat ready
//  op_a       in   4*MAC_MIN_WIDTH         {A3,A2,A1,A0}
//  op_b       in   4*MAC_MIN_WIDTH         {B3,B2,B1,B0}
//  mac_cset   out  1                       to cluster cset
//  mac_en     out  1                       to cluster en
//  mac_cfg    out  4*MAC_ACC_WIDTH+MAC_CONF_WIDTH  to cluster cfg
//  mac_a      out  4*MAC_MIN_WIDTH         to cluster A3..A0
//  mac_b      out  4*MAC_MIN_WIDTH         to cluster B3..B0
//  mac_out    in   4*MAC_ACC_WIDTH         {out3,out2,out1,out0} from cluster
//  res_valid  out  1                       result valid
//  res_ready  in   1                       result ready
//  res_data   out  4*MAC_ACC_WIDTH         captured {out3..out0}
//  busy       out  1                       high in any state other than IDLE
// BEHAVIOUR
//  - Handshakes: a transfer occurs on a cycle with valid&&ready. Valid, once high, is held with stable data until accepted.
//  - Reset: state=IDLE; cmd_ready=0 during rst, 1 on the first cycle after. op_ready, mac_cset, mac_en,
//    res_valid and busy = 0. mac_cfg, mac_a, mac_b and res_data = 0. Reset mid-job aborts without flushing.
//  - States: IDLE, LOAD, STREAM, DRAIN, DONE. All outputs are a decode of registered state and registers.
//  - IDLE: cmd_ready=1. On cmd accept: latch cfg into cfg_q and len into cnt. Next state is LOAD.
//  - LOAD (1 cycle): mac_cset=1, mac_en=1, mac_cfg=cfg_q. This loads init lanes into the cluster accumulators.
//    Next state is STREAM if cnt!=0, else DRAIN.
//  - STREAM: op_ready=1, mac_cfg=cfg_q. On each accepted beat: mac_a/mac_b take op_a/op_b and mac_en=1
//    for that one cycle (drive from a registered beat or combinationally; the choice must be documented).
//    Then cnt-=1. Bubble cycles (op_valid=0) drive mac_en=0 and mac_a=mac_b=0; the cluster holds state.
//    The beat that makes cnt reach 0 moves the state to DRAIN.
//  - DRAIN: exactly MAC_LAT cycles. mac_en=1, mac_a=mac_b=0, mac_cfg=cfg_q with bit[2] forced to 1.
//    Zero product with accumulate is idempotent, so outputs settle to the final value.
//    On the last DRAIN cycle: res_data<=mac_out, then go to DONE.
//  - DONE: res_valid=1, res_data held. On res_ready go to IDLE. No new command is accepted before IDLE.
//  - len=0 job: result equals the init lanes of cmd_cfg.
//  - Arithmetic is done entirely in the cluster. The counter decrements only on accepted beats; no wrap.
//    Max len is 2^LEN_WIDTH-1.
//  - op_valid outside STREAM is ignored (op_ready=0). cmd_valid outside IDLE is ignored.
//  - Throughput: one beat per cycle in STREAM. Job overhead is 1 (LOAD) + MAC_LAT (DRAIN) + 1 (DONE min) cycles.
// TESTING
//  1. SINGLE, acc, unsigned, init 0, len=3: every lane gets a=2,3,4 and b=5,5,5 -> res_data lanes = 45 each, res_valid 1+3+2 cycles after cmd accept.
//  2. SINGLE, non-acc, signed, len=2: lane0 a=-3,b=7 then a=-1,b=-1 -> lane0 = 1. The accumulate bit must not leak into the job (drain forced).
//  3. len=0, inits {4,3,2,1} -> res_data lanes 1,2,3,4. The STREAM state is skipped and op_ready is never asserted.
//  4. QUAD, acc, len=4 with op_valid toggling 1,0,0,1,1,0,1 -> matches golden 128-bit MAC. mac_en high exactly on 4 beat cycles plus 2 drain cycles.
//  5. Hold res_ready=0 for 10 cycles -> res_valid and res_data stable; cmd_ready=0 throughout. Accept -> cmd_ready=1 next cycle.
//  6. Assert rst during STREAM after 2 of 5 beats -> next cycle IDLE with all outputs at reset values. A new job then completes correctly.

Source files
------------

// File: rtl/mac_job_sequencer_if.sv
// rtl/mac_job_sequencer_if.sv - command, operand, cluster and result signals of the MAC job sequencer
interface mac_job_sequencer_if #(
  parameter int MAC_CONF_WIDTH = 4,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_ACC_WIDTH  = 4*MAC_MIN_WIDTH,
  parameter int LEN_WIDTH      = 16
);
  localparam int CFG_W = 4*MAC_ACC_WIDTH + MAC_CONF_WIDTH;

  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [CFG_W-1:0]           cmd_cfg;
  logic [LEN_WIDTH-1:0]       cmd_len;
  logic                       op_valid;
  logic                       op_ready;
  logic [4*MAC_MIN_WIDTH-1:0] op_a;
  logic [4*MAC_MIN_WIDTH-1:0] op_b;
  logic                       mac_cset;
  logic                       mac_en;
  logic [CFG_W-1:0]           mac_cfg;
  logic [4*MAC_MIN_WIDTH-1:0] mac_a;
  logic [4*MAC_MIN_WIDTH-1:0] mac_b;
  logic [4*MAC_ACC_WIDTH-1:0] mac_out;
  logic                       res_valid;
  logic                       res_ready;
  logic [4*MAC_ACC_WIDTH-1:0] res_data;
  logic                       busy;

  modport slave (
    input  cmd_valid, cmd_cfg, cmd_len, op_valid, op_a, op_b, mac_out, res_ready,
    output cmd_ready, op_ready, mac_cset, mac_en, mac_cfg, mac_a, mac_b, res_valid, res_data, busy
  );

  modport master (
    output cmd_valid, cmd_cfg, cmd_len, op_valid, op_a, op_b, mac_out, res_ready,
    input  cmd_ready, op_ready, mac_cset, mac_en, mac_cfg, mac_a, mac_b, res_valid, res_data, busy
  );
endinterface

// File: rtl/mac_job_sequencer.sv
// rtl/mac_job_sequencer.sv - drives one mac_cluster through load, stream, drain and result return
module mac_job_sequencer #(
  parameter int MAC_CONF_WIDTH = 4,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_ACC_WIDTH  = 4*MAC_MIN_WIDTH,
  parameter int MAC_LAT        = 2,
  parameter int LEN_WIDTH      = 16
) (
  input logic                clk,
  input logic                rst,
  mac_job_sequencer_if.slave bus
);
  localparam int CFG_W = 4*MAC_ACC_WIDTH + MAC_CONF_WIDTH;
  localparam int DW    = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [CFG_W-1:0] ACC_BIT = CFG_W'(4);

  logic [2:0]                 state;
  logic [CFG_W-1:0]           cfg_q;
  logic [LEN_WIDTH-1:0]       cnt;
  logic [DW-1:0]              drain_cnt;
  logic                       cmd_ready_q;
  logic [4*MAC_ACC_WIDTH-1:0] res_q;
  logic                       beat;

  // Beats reach the cluster combinationally in the cycle they are accepted,
  // so streaming needs no skid register and keeps one beat per cycle.
  assign beat = (state == S_STREAM) && bus.op_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cfg_q       <= '0;
      cnt         <= '0;
      drain_cnt   <= '0;
      cmd_ready_q <= 1'b0;
      res_q       <= '0;
    end else begin
      cmd_ready_q <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (bus.cmd_valid && cmd_ready_q) begin
            cfg_q       <= bus.cmd_cfg;
            cnt         <= bus.cmd_len;
            cmd_ready_q <= 1'b0;
            state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          drain_cnt <= '0;
          state     <= (cnt != '0) ? S_STREAM : S_DRAIN;
        end
        S_STREAM: begin
          if (bus.op_valid) begin
            cnt <= cnt - LEN_WIDTH'(1);
            if (cnt == LEN_WIDTH'(1)) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + DW'(1);
          if (drain_cnt == DW'(MAC_LAT-1)) begin
            res_q <= bus.mac_out;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.res_ready) begin
            cmd_ready_q <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.op_ready  = (state == S_STREAM);
  assign bus.mac_cset  = (state == S_LOAD);
  assign bus.mac_en    = (state == S_LOAD) || (state == S_DRAIN) || beat;
  assign bus.mac_a     = beat ? bus.op_a : '0;
  assign bus.mac_b     = beat ? bus.op_b : '0;
  assign bus.res_valid = (state == S_DONE);
  assign bus.res_data  = res_q;
  assign bus.busy      = (state != S_IDLE);

  // Drain feeds zero products with accumulate forced so the final sum is preserved.
  always_comb begin
    bus.mac_cfg = '0;
    case (state)
      S_LOAD, S_STREAM: bus.mac_cfg = cfg_q;
      S_DRAIN:          bus.mac_cfg = cfg_q | ACC_BIT;
      default:          bus.mac_cfg = '0;
    endcase
  end
endmodule

// File: tb/tb_mac_job_sequencer.sv
// tb/tb_mac_job_sequencer.sv - directed bench with a behavioural mac_cluster model
module tb_mac_job_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc_cnt = 0;
  int   accept_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  mac_job_sequencer_if #(.MAC_CONF_WIDTH(4), .MAC_MIN_WIDTH(8), .MAC_ACC_WIDTH(32), .LEN_WIDTH(16)) bus ();

  mac_job_sequencer #(.MAC_CONF_WIDTH(4), .MAC_MIN_WIDTH(8), .MAC_ACC_WIDTH(32), .MAC_LAT(2), .LEN_WIDTH(16))
    dut (.clk(clk), .rst(rst), .bus(bus));

  // Cluster model: mode 0/1/2 = 8/16/32-bit operands, accumulator 4x operand width.
  function automatic logic [127:0] mac_step(input logic [127:0] acc, input logic [3:0] ctrl,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [127:0] r, pa, pb, cur, nv, ow, aw;
    int w, n;
    r  = acc;
    w  = (ctrl[1:0] == 2'd0) ? 8 : (ctrl[1:0] == 2'd1) ? 16 : 32;
    n  = 32 / w;
    ow = (128'd1 << w) - 128'd1;
    aw = (w == 32) ? '1 : (128'd1 << (4*w)) - 128'd1;
    for (int i = 0; i < n; i++) begin
      pa = (128'(a) >> (i*w)) & ow;
      pb = (128'(b) >> (i*w)) & ow;
      if (ctrl[3]) begin
        if (pa[w-1]) pa = pa | ~ow;
        if (pb[w-1]) pb = pb | ~ow;
      end
      cur = (acc >> (i*4*w)) & aw;
      nv  = (ctrl[2] ? cur + pa*pb : pa*pb) & aw;
      r   = (r & ~(aw << (i*4*w))) | (nv << (i*4*w));
    end
    return r;
  endfunction

  logic [127:0] m_acc, m_out;
  always @(posedge clk) begin
    if (rst) begin
      m_acc <= '0;
      m_out <= '0;
    end else begin
      m_out <= m_acc;
      if (bus.mac_cset) m_acc <= bus.mac_cfg[131:4];
      else if (bus.mac_en) m_acc <= mac_step(m_acc, bus.mac_cfg[3:0], bus.mac_a, bus.mac_b);
    end
  end
  assign bus.mac_out = m_out;

  task automatic send_cmd(input logic [131:0] cfg, input logic [15:0] len);
    int n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_cfg = cfg; bus.cmd_len = len;
    while (!bus.cmd_ready && n < 50) begin @(negedge clk); n++; end
    total++;
    if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL cmd_accept_timeout cmd_ready=%b required=1", bus.cmd_ready); end
    @(posedge clk);
    @(negedge clk);
    accept_cyc = cyc_cnt;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    bus.op_valid = 1'b1; bus.op_a = a; bus.op_b = b;
    while (!bus.op_ready && n < 50) begin @(negedge clk); n++; end
    total++;
    if (bus.op_ready !== 1'b1) begin bad++; $display("FAIL op_accept_timeout op_ready=%b required=1", bus.op_ready); end
    @(posedge clk);
    @(negedge clk);
    bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0;
  endtask

  task automatic wait_res();
    int n = 0;
    while (!bus.res_valid && n < 200) begin @(negedge clk); n++; end
    total++;
    if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL res_valid_timeout res_valid=%b required=1", bus.res_valid); end
  endtask

  task automatic take_result();
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.cmd_ready, bus.op_ready, bus.mac_cset, bus.mac_en, bus.res_valid, bus.busy} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b required=000000",
                      {bus.cmd_ready, bus.op_ready, bus.mac_cset, bus.mac_en, bus.res_valid, bus.busy});
    end
    total++;
    if ({bus.mac_cfg, bus.mac_a, bus.mac_b, bus.res_data} !== '0) begin
      bad++; $display("FAIL reset_buses cfg=%h a=%h b=%h res=%h required=0", bus.mac_cfg, bus.mac_a, bus.mac_b, bus.res_data);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_release_cmd_ready got=%b required=1", bus.cmd_ready); end
  endtask

  task automatic test_single_acc();
    int dt;
    send_cmd({128'd0, 4'b0100}, 16'd3);
    total++;
    if ({bus.mac_cset, bus.mac_en, bus.busy} !== 3'b111) begin
      bad++; $display("FAIL load_flags got=%b required=111", {bus.mac_cset, bus.mac_en, bus.busy});
    end
    send_beat({4{8'd2}}, {4{8'd5}});
    send_beat({4{8'd3}}, {4{8'd5}});
    send_beat({4{8'd4}}, {4{8'd5}});
    wait_res();
    dt = cyc_cnt - accept_cyc;
    total++;
    if (dt != 6) begin bad++; $display("FAIL single_latency got=%0d required=6", dt); end
    total++;
    if (bus.res_data !== {4{32'd45}}) begin bad++; $display("FAIL single_acc_result got=%h required=%h", bus.res_data, {4{32'd45}}); end
    take_result();
  endtask

  task automatic test_signed_nonacc();
    send_cmd({{4{32'h55}}, 4'b1000}, 16'd2);
    send_beat(32'h0000_00FD, 32'h0000_0007);
    send_beat(32'h0000_00FF, 32'h0000_00FF);
    total++;
    if (bus.mac_cfg[2] !== 1'b1 || bus.mac_en !== 1'b1 || bus.mac_a !== 32'd0) begin
      bad++; $display("FAIL drain_drive acc_bit=%b en=%b a=%h required 1,1,0", bus.mac_cfg[2], bus.mac_en, bus.mac_a);
    end
    wait_res();
    total++;
    if (bus.res_data !== 128'd1) begin bad++; $display("FAIL signed_nonacc_result got=%h required=%h", bus.res_data, 128'd1); end
    take_result();
  endtask

  task automatic test_len_zero();
    int  n = 0;
    logic seen = 1'b0;
    send_cmd({32'd4, 32'd3, 32'd2, 32'd1, 4'b0000}, 16'd0);
    while (!bus.res_valid && n < 20) begin
      seen = seen | bus.op_ready;
      @(negedge clk); n++;
    end
    total++;
    if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL len0_timeout res_valid=%b required=1", bus.res_valid); end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL len0_op_ready got=%b required=0", seen); end
    total++;
    if (bus.res_data !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
      bad++; $display("FAIL len0_result got=%h required=%h", bus.res_data, {32'd4, 32'd3, 32'd2, 32'd1});
    end
    take_result();
  endtask

  task automatic test_quad_bubbles();
    logic [6:0]  pat = 7'b1011001;
    logic [31:0] qa[4];
    logic [31:0] qb[4];
    int k = 0;
    int n = 0;
    int en_cnt = 0;
    qa[0] = 32'h0001_0000; qb[0] = 32'h0001_0000;
    qa[1] = 32'hFFFF_FFFF; qb[1] = 32'd2;
    qa[2] = 32'd3;         qb[2] = 32'd4;
    qa[3] = 32'd5;         qb[3] = 32'd6;
    send_cmd({128'd0, 4'b0110}, 16'd4);
    @(negedge clk);
    for (int c = 0; c < 7; c++) begin
      bus.op_valid = pat[c];
      bus.op_a = pat[c] ? qa[k] : 32'd0;
      bus.op_b = pat[c] ? qb[k] : 32'd0;
      #1;
      if (bus.mac_en && !bus.mac_cset) en_cnt++;
      @(negedge clk);
      if (pat[c]) k++;
    end
    bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0;
    while (!bus.res_valid && n < 20) begin
      if (bus.mac_en && !bus.mac_cset) en_cnt++;
      @(negedge clk); n++;
    end
    total++;
    if (en_cnt != 6) begin bad++; $display("FAIL quad_en_count got=%0d required=6", en_cnt); end
    total++;
    if (bus.res_data !== 128'h0000_0000_0000_0000_0000_0003_0000_0028) begin
      bad++; $display("FAIL quad_result got=%h required=%h", bus.res_data, 128'h0000_0000_0000_0000_0000_0003_0000_0028);
    end
    take_result();
  endtask

  task automatic test_res_hold();
    send_cmd({128'd0, 4'b0100}, 16'd1);
    send_beat({4{8'd1}}, {4{8'd1}});
    wait_res();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (bus.res_valid !== 1'b1 || bus.cmd_ready !== 1'b0) begin
        bad++; $display("FAIL hold_flags cycle=%0d res_valid=%b cmd_ready=%b required 1,0", c, bus.res_valid, bus.cmd_ready);
      end
      total++;
      if (bus.res_data !== {4{32'd1}}) begin bad++; $display("FAIL hold_data cycle=%0d got=%h required=%h", c, bus.res_data, {4{32'd1}}); end
    end
    take_result();
    total++;
    if ({bus.cmd_ready, bus.res_valid, bus.busy} !== 3'b100) begin
      bad++; $display("FAIL hold_release got=%b required=100", {bus.cmd_ready, bus.res_valid, bus.busy});
    end
  endtask

  task automatic test_reset_mid_job();
    send_cmd({128'd0, 4'b0100}, 16'd5);
    send_beat({4{8'd1}}, {4{8'd1}});
    send_beat({4{8'd1}}, {4{8'd1}});
    rst = 1'b1;
    bus.op_valid = 1'b1; bus.op_a = {4{8'hAA}}; bus.op_b = {4{8'h55}};
    @(posedge clk);
    #1;
    total++;
    if ({bus.cmd_ready, bus.op_ready, bus.mac_cset, bus.mac_en, bus.res_valid, bus.busy} !== 6'b0) begin
      bad++; $display("FAIL midrst_flags got=%b required=000000",
                      {bus.cmd_ready, bus.op_ready, bus.mac_cset, bus.mac_en, bus.res_valid, bus.busy});
    end
    total++;
    if ({bus.mac_cfg, bus.mac_a, bus.mac_b, bus.res_data} !== '0) begin
      bad++; $display("FAIL midrst_buses cfg=%h a=%h b=%h res=%h required=0", bus.mac_cfg, bus.mac_a, bus.mac_b, bus.res_data);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0;
    send_cmd({{4{32'd7}}, 4'b0100}, 16'd2);
    send_beat({4{8'd1}}, {4{8'd1}});
    send_beat({4{8'd1}}, {4{8'd1}});
    wait_res();
    total++;
    if (bus.res_data !== {4{32'd9}}) begin bad++; $display("FAIL after_reset_job got=%h required=%h", bus.res_data, {4{32'd9}}); end
    take_result();
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_cfg = '0; bus.cmd_len = '0;
    bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_single_acc();
    test_signed_nonacc();
    test_len_zero();
    test_quad_bubbles();
    test_res_hold();
    test_reset_mid_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
